alu_issue_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_issue_seq_checker.sv | 27 ++
 rtl/alu_seq_regfile.sv | 40 ++++
 rtl/alu_issue_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue sequencer: opcode and FSM encodings, the
// reg_src codes that steer the ALU operand latches, and opcode classifiers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_NOT = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ASR = 4'd8,
    OP_CMP = 4'd9
  } alu_op_e;

  // reg_src codes the ALU decodes as "load operand A / operand B"
  localparam int unsigned A_REG_MAP = 16;
  localparam int unsigned B_REG_MAP = 17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } seq_state_e;

  // True for opcodes whose result is written back to the register file.
  function automatic logic op_writes_rf(input logic [3:0] op);
    logic wr_s;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND,
      OP_NOT, OP_LSL, OP_LSR, OP_ASR: wr_s = 1'b1;
      default:                         wr_s = 1'b0;
    endcase
    return wr_s;
  endfunction

  // True only for the compare opcode, which updates the latched flags.
  function automatic logic op_sets_flags(input logic [3:0] op);
    logic fl_s;
    case (op)
      OP_CMP:  fl_s = 1'b1;
      default: fl_s = 1'b0;
    endcase
    return fl_s;
  endfunction

endpackage

// File: rtl/alu_issue_seq_checker.sv
// Protocol invariants of the issue sequencer's ALU-side and handshake outputs.
module alu_issue_seq_checker
  import alu_pkg::*;
#(
  parameter int REG_SRC_W = 5
) (
  input logic                 sysclk,
  input logic                 rst,
  input logic                 instr_ready,
  input logic                 alu_en,
  input logic                 done,
  input logic [REG_SRC_W-1:0] reg_src
);

  localparam logic [REG_SRC_W-1:0] A_SRC = REG_SRC_W'(A_REG_MAP);
  localparam logic [REG_SRC_W-1:0] B_SRC = REG_SRC_W'(B_REG_MAP);

  a_done_single_cycle: assert property (
    @(posedge sysclk) disable iff (rst) done |=> !done);

  a_idle_is_quiet: assert property (
    @(posedge sysclk) disable iff (rst) instr_ready |-> (!alu_en && !done));

  a_enable_has_target: assert property (
    @(posedge sysclk) disable iff (rst) alu_en |-> (reg_src == A_SRC || reg_src == B_SRC));

endmodule

// File: rtl/alu_seq_regfile.sv
// Local register file for the issue sequencer: synchronous clear, one write
// port, two combinational operand read ports and a combinational debug port.
module alu_seq_regfile
  import alu_pkg::*;
#(
  parameter int ALU_WIDTH = 8,
  parameter int NUM_REGS  = 8,
  parameter int RA        = $clog2(NUM_REGS)
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [RA-1:0]        wr_addr,
  input  logic [ALU_WIDTH-1:0] wr_data,
  input  logic [RA-1:0]        rd_addr_a,
  output logic [ALU_WIDTH-1:0] rd_data_a,
  input  logic [RA-1:0]        rd_addr_b,
  output logic [ALU_WIDTH-1:0] rd_data_b,
  input  logic [RA-1:0]        dbg_addr,
  output logic [ALU_WIDTH-1:0] dbg_data
);

  logic [ALU_WIDTH-1:0] mem_r [NUM_REGS];

  // Storage: reset clears every entry, otherwise the single write port lands.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem_r[rd_addr_a];
  assign rd_data_b = mem_r[rd_addr_b];
  assign dbg_data  = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the bus-attached ALU. Takes one register-register
// instruction, walks it through LOAD_A -> LOAD_B -> EXEC -> WB, and writes the
// result (or the compare flags) back. All ALU-side outputs are registered, so
// each is computed one edge ahead from the state being entered.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int ALU_WIDTH = 8,
  parameter int ALU_OPS   = 16,
  parameter int NUM_REGS  = 8,
  parameter int REG_SRC_W = 5,
  localparam int OP_W     = $clog2(ALU_OPS),
  localparam int RA       = $clog2(NUM_REGS)
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OP_W-1:0]      instr_op,
  input  logic [RA-1:0]        instr_rs1,
  input  logic [RA-1:0]        instr_rs2,
  input  logic [RA-1:0]        instr_rd,
  input  logic                 host_wr_en,
  input  logic [RA-1:0]        host_wr_addr,
  input  logic [ALU_WIDTH-1:0] host_wr_data,
  input  logic [RA-1:0]        dbg_rd_addr,
  output logic [ALU_WIDTH-1:0] dbg_rd_data,
  output logic [ALU_WIDTH-1:0] A_bus,
  output logic [ALU_WIDTH-1:0] B_bus,
  output logic [OP_W-1:0]      alu_op,
  output logic                 alu_en,
  output logic [REG_SRC_W-1:0] reg_src,
  input  logic [ALU_WIDTH-1:0] alu_result,
  input  logic                 cc_greater,
  input  logic                 cc_equal,
  output logic                 flag_gt,
  output logic                 flag_eq,
  output logic                 done
);

  localparam logic [REG_SRC_W-1:0] A_SRC = REG_SRC_W'(A_REG_MAP);
  localparam logic [REG_SRC_W-1:0] B_SRC = REG_SRC_W'(B_REG_MAP);

  seq_state_e           state_r;
  logic [OP_W-1:0]      op_r;
  logic [RA-1:0]        rs2_r;
  logic [RA-1:0]        rd_r;
  logic [ALU_WIDTH-1:0] res_r;      // result sampled in EXEC
  logic [1:0]           cc_r;       // {gt, eq} sampled in EXEC

  logic                 instr_ready_r;
  logic [ALU_WIDTH-1:0] a_bus_r;
  logic [ALU_WIDTH-1:0] b_bus_r;
  logic [OP_W-1:0]      alu_op_r;
  logic                 alu_en_r;
  logic [REG_SRC_W-1:0] reg_src_r;
  logic                 flag_gt_r;
  logic                 flag_eq_r;
  logic                 done_r;

  logic                 rf_we_s;
  logic [RA-1:0]        rf_waddr_s;
  logic [ALU_WIDTH-1:0] rf_wdata_s;
  logic [ALU_WIDTH-1:0] rf_rd_a_s;
  logic [ALU_WIDTH-1:0] rf_rd_b_s;
  logic [ALU_WIDTH-1:0] opa_next_s;
  logic                 accept_s;

  assign accept_s = (state_r == S_IDLE) && instr_valid && instr_ready_r;

  // Write-port arbitration: WB retirement, else a host write while idle.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = '0;
    rf_wdata_s = '0;
    if ((state_r == S_WB) && op_writes_rf(op_r)) begin
      rf_we_s    = 1'b1;
      rf_waddr_s = rd_r;
      rf_wdata_s = res_r;
    end else if (host_wr_en && (state_r == S_IDLE)) begin
      rf_we_s    = 1'b1;
      rf_waddr_s = host_wr_addr;
      rf_wdata_s = host_wr_data;
    end else begin
      rf_we_s    = 1'b0;
    end
  end

  // Operand A is registered at the accept edge, so forward a same-cycle host
  // write to rs1 so that it is already visible on A_bus in LOAD_A.
  always_comb begin
    opa_next_s = rf_rd_a_s;
    if (rf_we_s && (rf_waddr_s == instr_rs1)) begin
      opa_next_s = rf_wdata_s;
    end else begin
      opa_next_s = rf_rd_a_s;
    end
  end

  alu_seq_regfile #(
    .ALU_WIDTH (ALU_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RA        (RA)
  ) u_regfile (
    .sysclk    (sysclk),
    .rst       (rst),
    .wr_en     (rf_we_s),
    .wr_addr   (rf_waddr_s),
    .wr_data   (rf_wdata_s),
    .rd_addr_a (instr_rs1),
    .rd_data_a (rf_rd_a_s),
    .rd_addr_b (rs2_r),
    .rd_data_b (rf_rd_b_s),
    .dbg_addr  (dbg_rd_addr),
    .dbg_data  (dbg_rd_data)
  );

  // Sequencer FSM; outputs are set for the state being entered and cleared
  // by default so bus and control lines are zero outside active cycles.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      op_r          <= '0;
      rs2_r         <= '0;
      rd_r          <= '0;
      res_r         <= '0;
      cc_r          <= 2'b00;
      instr_ready_r <= 1'b1;
      a_bus_r       <= '0;
      b_bus_r       <= '0;
      alu_op_r      <= '0;
      alu_en_r      <= 1'b0;
      reg_src_r     <= '0;
      flag_gt_r     <= 1'b0;
      flag_eq_r     <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      a_bus_r   <= '0;
      b_bus_r   <= '0;
      alu_op_r  <= '0;
      alu_en_r  <= 1'b0;
      reg_src_r <= '0;
      done_r    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r          <= instr_op;
            rs2_r         <= instr_rs2;
            rd_r          <= instr_rd;
            instr_ready_r <= 1'b0;
            a_bus_r       <= opa_next_s;
            reg_src_r     <= A_SRC;
            alu_en_r      <= 1'b1;
            state_r       <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          b_bus_r   <= rf_rd_b_s;
          reg_src_r <= B_SRC;
          alu_en_r  <= 1'b1;
          state_r   <= S_LOAD_B;
        end
        S_LOAD_B: begin
          alu_op_r <= op_r;
          state_r  <= S_EXEC;
        end
        S_EXEC: begin
          res_r   <= alu_result;
          cc_r    <= {cc_greater, cc_equal};
          done_r  <= 1'b1;
          state_r <= S_WB;
        end
        S_WB: begin
          if (op_sets_flags(op_r)) begin
            flag_gt_r <= cc_r[1];
            flag_eq_r <= cc_r[0];
          end
          instr_ready_r <= 1'b1;
          state_r       <= S_IDLE;
        end
        default: begin
          instr_ready_r <= 1'b1;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_r;
  assign A_bus       = a_bus_r;
  assign B_bus       = b_bus_r;
  assign alu_op      = alu_op_r;
  assign alu_en      = alu_en_r;
  assign reg_src     = reg_src_r;
  assign flag_gt     = flag_gt_r;
  assign flag_eq     = flag_eq_r;
  assign done        = done_r;

  alu_issue_seq_checker #(
    .REG_SRC_W   (REG_SRC_W)
  ) u_checker (
    .sysclk      (sysclk),
    .rst         (rst),
    .instr_ready (instr_ready_r),
    .alu_en      (alu_en_r),
    .done        (done_r),
    .reg_src     (reg_src_r)
  );

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: a behavioural ALU partner on the
// operand buses, a directed vector table, hand-written multi-cycle sequences
// and randomized instructions checked against an array-based register model.
module tb_alu_issue_seq;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_rs1, instr_rs2, instr_rd;
  logic       host_wr_en;
  logic [2:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic [2:0] dbg_rd_addr;
  logic [7:0] dbg_rd_data;
  logic [7:0] A_bus, B_bus;
  logic [3:0] alu_op;
  logic       alu_en;
  logic [4:0] reg_src;
  logic [7:0] alu_result;
  logic       cc_greater, cc_equal;
  logic       flag_gt, flag_eq, done;

  int total = 0;
  int bad   = 0;
  int m_rf [8];
  int m_gt = 0;
  int m_eq = 0;

  always #20 sysclk = ~sysclk;

  alu_issue_seq #(
    .ALU_WIDTH(8), .ALU_OPS(16), .NUM_REGS(8), .REG_SRC_W(5)
  ) dut (
    .sysclk(sysclk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .A_bus(A_bus), .B_bus(B_bus),
    .alu_op(alu_op), .alu_en(alu_en), .reg_src(reg_src),
    .alu_result(alu_result), .cc_greater(cc_greater), .cc_equal(cc_equal),
    .flag_gt(flag_gt), .flag_eq(flag_eq), .done(done)
  );

  // alu_unit_interface: operand latches loaded by reg_src codes, combinational result
  logic [7:0] alu_a_q = 8'h00;
  logic [7:0] alu_b_q = 8'h00;
  always @(posedge sysclk) begin
    if (alu_en && reg_src == 5'd16) alu_a_q <= A_bus;
    if (alu_en && reg_src == 5'd17) alu_b_q <= B_bus;
  end
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      4'd1:    alu_result = alu_a_q + alu_b_q;
      4'd2:    alu_result = alu_a_q - alu_b_q;
      4'd3:    alu_result = alu_a_q | alu_b_q;
      4'd4:    alu_result = alu_a_q & alu_b_q;
      4'd5:    alu_result = ~alu_a_q;
      4'd6:    alu_result = alu_a_q << alu_b_q[2:0];
      4'd7:    alu_result = alu_a_q >> alu_b_q[2:0];
      4'd8:    alu_result = $signed(alu_a_q) >>> alu_b_q[2:0];
      4'd9:    alu_result = alu_a_q - alu_b_q;
      default: alu_result = 8'h00;
    endcase
  end
  assign cc_greater = (alu_a_q > alu_b_q);
  assign cc_equal   = (alu_a_q == alu_b_q);

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] d;
    logic [7:0] exp_rd;
    logic       exp_gt;
    logic       exp_eq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register contents per the opcode rules, plain integer math.
  function automatic void model_exec(input int op, input int s1, input int s2, input int d);
    int a, b, sh, r, sa;
    bit wr;
    a = m_rf[s1]; b = m_rf[s2]; sh = b % 8; r = 0; wr = 1'b1;
    case (op)
      1: r = (a + b) % 256;
      2: r = (a - b + 256) % 256;
      3: r = a | b;
      4: r = a & b;
      5: r = 255 - a;
      6: r = (a * (1 << sh)) % 256;
      7: r = a / (1 << sh);
      8: begin sa = (a >= 128) ? a - 256 : a; r = (sa >>> sh) & 255; end
      9: begin wr = 1'b0; m_gt = (a > b) ? 1 : 0; m_eq = (a == b) ? 1 : 0; end
      default: wr = 1'b0;
    endcase
    if (wr) m_rf[d] = r;
  endfunction

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_rd_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(dbg_rd_data), 32'(m_rf[i]));
    end
    chk($sformatf("%s_flag_gt", tag), 32'(flag_gt), 32'(m_gt));
    chk($sformatf("%s_flag_eq", tag), 32'(flag_eq), 32'(m_eq));
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] dv);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = dv;
    @(negedge sysclk);
    host_wr_en = 1'b0;
    m_rf[a] = dv;
  endtask

  // One instruction, checked cycle by cycle; called with the DUT idle.
  // hw: host write in the accept cycle; bw: host write held while busy.
  task automatic issue(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input bit hw, input logic [2:0] ha,
                       input logic [7:0] hd, input bit bw);
    int n;
    int a_exp, b_exp;
    instr_op = op; instr_rs1 = s1; instr_rs2 = s2; instr_rd = d; instr_valid = 1'b1;
    host_wr_en = hw; host_wr_addr = ha; host_wr_data = hd;
    n = 0;
    while (!instr_ready && n < 16) begin @(negedge sysclk); n++; end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    if (hw) m_rf[ha] = hd;
    a_exp = m_rf[s1]; b_exp = m_rf[s2];
    @(negedge sysclk);
    instr_valid = 1'b0;
    host_wr_en = bw; host_wr_addr = 3'd0; host_wr_data = 8'h77;
    chk("loadA_A_bus", 32'(A_bus), 32'(a_exp));
    chk("loadA_B_bus", 32'(B_bus), 32'd0);
    chk("loadA_reg_src", 32'(reg_src), 32'd16);
    chk("loadA_alu_en", 32'(alu_en), 32'd1);
    chk("loadA_ready", 32'(instr_ready), 32'd0);
    @(negedge sysclk);
    chk("loadB_B_bus", 32'(B_bus), 32'(b_exp));
    chk("loadB_A_bus", 32'(A_bus), 32'd0);
    chk("loadB_reg_src", 32'(reg_src), 32'd17);
    chk("loadB_alu_en", 32'(alu_en), 32'd1);
    @(negedge sysclk);
    chk("exec_alu_op", 32'(alu_op), 32'(op));
    chk("exec_alu_en", 32'(alu_en), 32'd0);
    chk("exec_reg_src", 32'(reg_src), 32'd0);
    chk("exec_done", 32'(done), 32'd0);
    @(negedge sysclk);
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_alu_op", 32'(alu_op), 32'd0);
    chk("wb_ready", 32'(instr_ready), 32'd0);
    model_exec(int'(op), int'(s1), int'(s2), int'(d));
    @(negedge sysclk);
    host_wr_en = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_ready", 32'(instr_ready), 32'd1);
    check_rf("post_instr");
  endtask

  // instr_valid held high across two instructions: period and ready gap.
  task automatic run_back_to_back();
    int acc_k [2];
    int nacc, low, n;
    nacc = 0; low = 0; acc_k[0] = 0; acc_k[1] = 0;
    instr_op = 4'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_rd = 3'd3;
    instr_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (instr_ready) begin
        acc_k[nacc] = k;
        nacc++;
      end else if (nacc == 1) begin
        low++;
      end
      @(negedge sysclk);
      if (nacc == 2) break;
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_period", 32'(acc_k[1] - acc_k[0]), 32'd5);
    chk("b2b_ready_low", 32'(low), 32'd4);
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge sysclk); n++; end
    chk("b2b_back_idle", 32'(instr_ready), 32'd1);
    model_exec(1, 1, 2, 3);
    model_exec(1, 1, 2, 3);
    check_rf("b2b");
  endtask

  // Reset during EXEC of an add to r3 aborts it cleanly.
  task automatic run_reset_abort();
    instr_op = 4'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_rd = 3'd3;
    instr_valid = 1'b1;
    chk("rst_seq_ready", 32'(instr_ready), 32'd1);
    @(negedge sysclk);
    instr_valid = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("rst_seq_exec_op", 32'(alu_op), 32'd1);
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    chk("rst_abort_done", 32'(done), 32'd0);
    chk("rst_abort_ready", 32'(instr_ready), 32'd1);
    chk("rst_abort_alu_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_gt = 0; m_eq = 0;
    @(negedge sysclk);
    chk("rst_abort_no_done", 32'(done), 32'd0);
    check_rf("rst_abort");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic [2:0] s1, s2, d, ha;
    bit hw;
    tbl[0] = '{op: 4'd1, s1: 3'd1, s2: 3'd2, d: 3'd3, exp_rd: 8'h08, exp_gt: 1'b0, exp_eq: 1'b0};
    tbl[1] = '{op: 4'd2, s1: 3'd1, s2: 3'd2, d: 3'd5, exp_rd: 8'h02, exp_gt: 1'b0, exp_eq: 1'b0};
    tbl[2] = '{op: 4'd2, s1: 3'd2, s2: 3'd1, d: 3'd6, exp_rd: 8'hFE, exp_gt: 1'b0, exp_eq: 1'b0};
    tbl[3] = '{op: 4'd9, s1: 3'd1, s2: 3'd2, d: 3'd7, exp_rd: 8'h00, exp_gt: 1'b1, exp_eq: 1'b0};
    tbl[4] = '{op: 4'd9, s1: 3'd1, s2: 3'd1, d: 3'd7, exp_rd: 8'h00, exp_gt: 1'b0, exp_eq: 1'b1};
    tbl[5] = '{op: 4'hC, s1: 3'd1, s2: 3'd2, d: 3'd4, exp_rd: 8'hAA, exp_gt: 1'b0, exp_eq: 1'b1};
    for (int i = 0; i < 8; i++) m_rf[i] = 0;

    rst = 1'b1; instr_valid = 1'b0; instr_op = 4'd0;
    instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_rd = 3'd0;
    host_wr_en = 1'b0; host_wr_addr = 3'd0; host_wr_data = 8'h00; dbg_rd_addr = 3'd0;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;

    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_alu_en", 32'(alu_en), 32'd0);
    chk("reset_reg_src", 32'(reg_src), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    chk("reset_A_bus", 32'(A_bus), 32'd0);
    chk("reset_B_bus", 32'(B_bus), 32'd0);
    check_rf("reset");

    host_write(3'd1, 8'h05);
    host_write(3'd2, 8'h03);
    host_write(3'd4, 8'hAA);

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].d, 1'b0, 3'd0, 8'h00, 1'b0);
      dbg_rd_addr = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_rd", i), 32'(dbg_rd_data), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_gt", i), 32'(flag_gt), 32'(tbl[i].exp_gt));
      chk($sformatf("vec%0d_eq", i), 32'(flag_eq), 32'(tbl[i].exp_eq));
    end

    // host write to rs1 in the accept cycle is seen on A_bus; busy write ignored
    issue(4'd1, 3'd6, 3'd2, 3'd7, 1'b1, 3'd6, 8'h40, 1'b1);
    host_write(3'd3, 8'h08);

    run_back_to_back();
    run_reset_abort();

    for (int i = 0; i < 8; i++) host_write(3'(i), 8'($urandom_range(0, 255)));
    for (int t = 0; t < 60; t++) begin
      s1 = 3'($urandom_range(0, 7));
      s2 = 3'($urandom_range(0, 7));
      d  = 3'($urandom_range(0, 7));
      hw = ($urandom_range(0, 3) == 0);
      ha = ($urandom_range(0, 1) == 0) ? s1 : 3'($urandom_range(0, 7));
      issue(4'($urandom_range(0, 15)), s1, s2, d, hw, ha,
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
